// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter
//   Shares one AES-128 core between two requesters. Round-robin selection in
//   IDLE, latches the winner's plaintext/key, pulses core_start, waits for
//   core_done under a watchdog, and returns the result tagged with the
//   requester ID on a single valid/ready response channel.
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   reqN_valid/ready         request handshake per requester (N = 0, 1)
//   reqN_plaintext/key       128-bit block and cipher key per requester
//   core_start               one-cycle start pulse to the core
//   core_plaintext/key       held core inputs, change only on acceptance
//   core_rst                 one-cycle core flush on watchdog expiry
//   core_done/ciphertext     core completion and result
//   rsp_valid/ready          response handshake
//   rsp_id/data/err          requester index, ciphertext (0 on error), timeout flag
//   busy                     high whenever the sequencer is not idle
module aes_req_arbiter #(
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned TO_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_plaintext,
  input  logic [127:0] req1_plaintext,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  output logic         core_start,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  output logic         core_rst,
  input  logic         core_done,
  input  logic [127:0] core_ciphertext,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q;
  logic            last_grant_q;
  logic [TO_W-1:0] timer_q;
  logic [127:0]    pt_q;
  logic [127:0]    key_q;
  logic [127:0]    data_q;
  logic            id_q;
  logic            err_q;
  logic            start_q;
  logic            valid_q;
  logic            busy_q;

  logic            grant0;
  logic            grant1;
  logic            accept;
  logic            timer_last;

  // Ready is combinational from IDLE; with both pending, the requester that
  // did not win last time is granted (last_grant_q = 1 favours req0).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == S_IDLE) && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept     = grant0 | grant1;
  assign timer_last = (timer_q == TO_W'(TIMEOUT - 1));

  // core_rst must be high in the expiry cycle itself and suppressed when
  // core_done lands in that same cycle, so it is decoded rather than registered.
  assign core_rst = (state_q == S_WAIT) && timer_last && !core_done && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      pt_q         <= '0;
      key_q        <= '0;
      data_q       <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            pt_q         <= grant1 ? req1_plaintext : req0_plaintext;
            key_q        <= grant1 ? req1_key : req0_key;
            id_q         <= grant1;
            last_grant_q <= grant1;
            start_q      <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          // any core_done seen here belongs to an earlier job and is dropped
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_q + TO_W'(1);
          if (core_done) begin
            data_q  <= core_ciphertext;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_RESP;
          end else if (timer_last) begin
            data_q  <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready     = grant0;
  assign req1_ready     = grant1;
  assign core_start     = start_q;
  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign rsp_valid      = valid_q;
  assign rsp_id         = id_q;
  assign rsp_data       = data_q;
  assign rsp_err        = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter. Instance "dut" (TIMEOUT = 200) is driven by a
// per-cycle requester/core/consumer model with a response scoreboard;
// instance "dut_to" (TIMEOUT = 8) is driven cycle by cycle for watchdog cases.
module tb_aes_req_arbiter;

  localparam logic [127:0] KPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic         id;
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_plaintext = '0, req1_plaintext = '0;
  logic [127:0] req0_key = '0, req1_key = '0;
  logic         core_start, core_rst;
  logic [127:0] core_plaintext, core_key;
  logic         core_done = 1'b0;
  logic [127:0] core_ciphertext = '0;
  logic         rsp_valid, rsp_id, rsp_err, busy;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;

  // short-timeout instance
  logic         b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic         b_req0_ready, b_req1_ready;
  logic [127:0] b_req0_plaintext = '0, b_req1_plaintext = '0;
  logic [127:0] b_req0_key = '0, b_req1_key = '0;
  logic         b_core_start, b_core_rst;
  logic [127:0] b_core_plaintext, b_core_key;
  logic         b_core_done = 1'b0;
  logic [127:0] b_core_ciphertext = '0;
  logic         b_rsp_valid, b_rsp_id, b_rsp_err, b_busy;
  logic         b_rsp_ready = 1'b0;
  logic [127:0] b_rsp_data;

  aes_req_arbiter #(.TIMEOUT(200), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_plaintext(req0_plaintext), .req1_plaintext(req1_plaintext),
    .req0_key(req0_key), .req1_key(req1_key),
    .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_rst(core_rst), .core_done(core_done), .core_ciphertext(core_ciphertext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  aes_req_arbiter #(.TIMEOUT(8), .TO_W(4)) dut_to (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req1_valid(b_req1_valid),
    .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
    .req0_plaintext(b_req0_plaintext), .req1_plaintext(b_req1_plaintext),
    .req0_key(b_req0_key), .req1_key(b_req1_key),
    .core_start(b_core_start), .core_plaintext(b_core_plaintext), .core_key(b_core_key),
    .core_rst(b_core_rst), .core_done(b_core_done), .core_ciphertext(b_core_ciphertext),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
    .rsp_data(b_rsp_data), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // stand-in core transform; the known vector pair yields the reference ciphertext
  function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [127:0] key);
    if (pt == KPT && key == KKEY) return KCT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9669_6996;
  endfunction

  int kv_seq = -1;  // req0 job index that carries the known vector

  function automatic logic [127:0] src_pt(input int unsigned id, input int unsigned seq);
    if (id == 0 && int'(seq) == kv_seq) return KPT;
    return {8'(32'hA0 + id), 24'(seq), 96'h0123_4567_89ab_cdef_0011_2233};
  endfunction

  function automatic logic [127:0] src_key(input int unsigned id, input int unsigned seq);
    if (id == 0 && int'(seq) == kv_seq) return KKEY;
    return {96'hfedc_ba98_7654_3210_aabb_ccdd, 8'(id), 24'(seq)};
  endfunction

  // model state: main process writes the *_cfg knobs and target[], the
  // monitor writes everything else
  int unsigned  target [2] = '{0, 0};
  int unsigned  granted[2] = '{0, 0};
  int unsigned  lat_cfg = 5, stall_cfg = 0;
  bit           inject = 1'b0;
  exp_t         sb[$];
  int           grant_log[$];
  bit           in_job = 1'b0;
  logic         last_grant_m = 1'b1;
  bit           prev_rsp_valid = 1'b0;
  int           cyc = 0, acc_cyc = 0, done_cyc = 0;
  int unsigned  cnt = 0, rsp_cnt = 0;
  logic [127:0] cap_pt = '0, cap_key = '0;
  logic         v0, v1, w_any, w_id;
  exp_t         e;

  always @(negedge clk) begin
    #2;
    cyc++;
    req0_valid     = granted[0] < target[0];
    req1_valid     = granted[1] < target[1];
    req0_plaintext = src_pt(0, granted[0]);
    req0_key       = src_key(0, granted[0]);
    req1_plaintext = src_pt(1, granted[1]);
    req1_key       = src_key(1, granted[1]);
    if (reset) begin
      sb.delete();
      in_job         = 1'b0;
      last_grant_m   = 1'b1;
      cnt            = 0;
      core_done      = 1'b0;
      rsp_ready      = 1'b0;
      rsp_cnt        = 0;
      prev_rsp_valid = 1'b0;
    end else begin
      // core model: done is driven lat_cfg cycles after the START cycle
      if (core_done) core_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          check_eq("pt_hold", core_plaintext, cap_pt);
          check_eq("key_hold", core_key, cap_key);
          core_done       = 1'b1;
          core_ciphertext = cipher(cap_pt, cap_key);
          done_cyc        = cyc;
        end
      end
      if (inject && rsp_valid && rsp_cnt == 3) begin
        core_done       = 1'b1;
        core_ciphertext = '1;
      end
      if (core_start) begin
        check_eq("start_lat", 128'(cyc - acc_cyc), 128'(1));
        cap_pt  = core_plaintext;
        cap_key = core_key;
        cnt     = lat_cfg;
      end
      rsp_ready = rsp_valid ? (rsp_cnt >= stall_cfg) : 1'($urandom_range(0, 1));
      #1;
      check_eq("busy", 128'(busy), 128'(in_job));
      check_eq("core_rst", 128'(core_rst), 128'(0));
      if (in_job) begin
        check_eq("rdy0_busy", 128'(req0_ready), 128'(0));
        check_eq("rdy1_busy", 128'(req1_ready), 128'(0));
      end else begin
        v0    = req0_valid;
        v1    = req1_valid;
        w_any = v0 | v1;
        w_id  = (v0 && v1) ? ~last_grant_m : v1;
        check_eq("rdy0", 128'(req0_ready), 128'(w_any && !w_id));
        check_eq("rdy1", 128'(req1_ready), 128'(w_any && w_id));
        if (w_any) begin
          sb.push_back('{id: w_id,
                         data: w_id ? cipher(req1_plaintext, req1_key)
                                    : cipher(req0_plaintext, req0_key),
                         err: 1'b0});
          last_grant_m = w_id;
          in_job       = 1'b1;
          acc_cyc      = cyc;
          granted[int'(w_id)]++;
          grant_log.push_back(int'(w_id));
        end
      end
      if (rsp_valid) begin
        if (!prev_rsp_valid) check_eq("rsp_lat", 128'(cyc - done_cyc), 128'(1));
        if (sb.size() == 0) begin
          check_eq("rsp_unexp", 128'(1), 128'(0));
        end else begin
          e = sb[0];
          check_eq("rsp_id", 128'(rsp_id), 128'(e.id));
          check_eq("rsp_data", rsp_data, e.data);
          check_eq("rsp_err", 128'(rsp_err), 128'(e.err));
        end
        if (rsp_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          in_job  = 1'b0;
          rsp_cnt = 0;
        end else begin
          rsp_cnt++;
        end
      end
      prev_rsp_valid = rsp_valid;
    end
  end

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (!(granted[0] == target[0] && granted[1] == target[1] && !in_job &&
             sb.size() == 0) && n < budget) begin
      @(negedge clk);
      #4;
      n++;
    end
    check_eq("done_in_budget", 128'(n < budget), 128'(1));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctl"}, 128'({core_start, core_rst, rsp_valid, busy, rsp_id,
                                  rsp_err, req0_ready, req1_ready}), 128'(0));
    check_eq({tag, "_data"}, rsp_data | core_plaintext | core_key, 128'(0));
  endtask

  int unsigned glog_base;
  int unsigned rst_cnt;

  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #3;
    check_idle_outputs("reset_a");
    check_eq("reset_b", 128'({b_core_start, b_core_rst, b_rsp_valid, b_busy, b_rsp_id,
                              b_rsp_err}) | b_rsp_data | b_core_key, 128'(0));

    // single request, known vector, 50-cycle core
    @(negedge clk);
    #1;
    kv_seq    = int'(granted[0]);
    lat_cfg   = 50;
    glog_base = grant_log.size();
    target[0] = granted[0] + 1;
    wait_done(200);
    check_eq("t1_grant", 128'(grant_log.size() > glog_base ? grant_log[glog_base] : -1), 128'(0));

    // continuous contention from reset: expect 0,1,0,1
    pulse_reset();
    #1;
    lat_cfg   = 5;
    glog_base = grant_log.size();
    target[0] = granted[0] + 2;
    target[1] = granted[1] + 2;
    wait_done(400);
    check_eq("t2_count", 128'(grant_log.size() - glog_base), 128'(4));
    for (int unsigned i = 0; i < 4; i++)
      if (glog_base + i < grant_log.size())
        check_eq("t2_order", 128'(grant_log[glog_base + i]), 128'(i % 2));

    // response back-pressure with a stray core_done during RESP
    @(negedge clk);
    #1;
    lat_cfg   = 7;
    stall_cfg = 10;
    inject    = 1'b1;
    target[0] = granted[0] + 1;
    target[1] = granted[1] + 1;
    wait_done(400);
    stall_cfg = 0;
    inject    = 1'b0;

    // watchdog expiry on the short-timeout instance, then late done in RESP and IDLE
    rst_cnt = 0;
    for (int unsigned k = 0; k <= 14; k++) begin
      @(negedge clk);
      #1;
      b_req0_valid      = (k == 0);
      b_req0_plaintext  = KPT;
      b_req0_key        = KKEY;
      b_core_done       = (k == 11) || (k == 13);
      b_core_ciphertext = '1;
      b_rsp_ready       = (k == 12);
      #2;
      if (k == 0) check_eq("b_rdy0", 128'(b_req0_ready), 128'(1));
      check_eq("b_start", 128'(b_core_start), 128'(k == 1));
      check_eq("b_rst", 128'(b_core_rst), 128'(k == 9));
      rst_cnt += 32'(b_core_rst);
      if (k >= 10 && k <= 12) begin
        check_eq("b_to_valid", 128'(b_rsp_valid), 128'(1));
        check_eq("b_to_err", 128'(b_rsp_err), 128'(1));
        check_eq("b_to_data", b_rsp_data, 128'(0));
        check_eq("b_to_id", 128'(b_rsp_id), 128'(0));
      end
      if (k >= 13) check_eq("b_to_idle", 128'({b_rsp_valid, b_busy}), 128'(0));
    end
    check_eq("b_rst_count", 128'(rst_cnt), 128'(1));

    // done coincides with the expiry cycle: done wins, no flush
    for (int unsigned k = 0; k <= 12; k++) begin
      @(negedge clk);
      #1;
      b_req1_valid      = (k == 0);
      b_req1_plaintext  = KPT;
      b_req1_key        = KKEY;
      b_core_done       = (k == 9);
      b_core_ciphertext = KCT;
      b_rsp_ready       = (k == 11);
      #2;
      if (k == 0) check_eq("b_rdy1", 128'(b_req1_ready), 128'(1));
      check_eq("b_edge_rst", 128'(b_core_rst), 128'(0));
      if (k >= 10 && k <= 11) begin
        check_eq("b_edge_valid", 128'(b_rsp_valid), 128'(1));
        check_eq("b_edge_err", 128'(b_rsp_err), 128'(0));
        check_eq("b_edge_data", b_rsp_data, KCT);
        check_eq("b_edge_id", 128'(b_rsp_id), 128'(1));
      end
      if (k == 12) check_eq("b_edge_idle", 128'(b_busy), 128'(0));
    end

    // reset while the main instance is waiting on the core
    @(negedge clk);
    #1;
    lat_cfg   = 100000;
    target[1] = granted[1] + 1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("mid_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    #2;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    #1;
    lat_cfg   = 5;
    glog_base = grant_log.size();
    target[0] = granted[0] + 1;
    target[1] = granted[1] + 1;
    wait_done(200);
    check_eq("post_reset_win", 128'(grant_log.size() > glog_base ? grant_log[glog_base] : -1), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
